// File: rtl/mul_256b_seq.sv
// ---------------------------------------------------------------------------
// mul_256b_seq
//
// Builds a full 256x256 -> 512-bit product from four passes through the
// shared 128x128 multiplier (mul_ko_128b). The operands are split into
// 128-bit halves and latched on accept. One partial product is issued per
// pass, and each 256-bit result is shift-added into a 512-bit accumulator.
//
// Pass order (idx : operands : shift)
//   0 : a_lo*b_lo : 0
//   1 : a_lo*b_hi : 128
//   2 : a_hi*b_lo : 128
//   3 : a_hi*b_hi : 256
//
// Optional feature (macro MUL_SQR_EN):
//   When a == b at accept, pass 2 is skipped and pass 1 is added at
//   shift 129, which doubles the cross term. Without the macro there is no
//   comparator, and every operation takes four passes.
//
// Handshake (both sides):
//   The request is a level. mul_vld_i is sampled only in IDLE. sub_vld_o is
//   held high, with stable operands, from issue until sub_fin_i is seen in
//   RUN. It then drops for at least one cycle, so the sub-multiplier always
//   sees vld low between operations. mul_fin_o is a one-cycle pulse. mul_r_o
//   is valid from that cycle and holds until the next pulse.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   mul_vld_i       operation request (level, IDLE only)
//   mul_a_i/b_i     256-bit operands, latched on accept
//   mul_fin_o       one-cycle done pulse
//   mul_r_o         512-bit product
//   busy_o          high in every state except IDLE
//   sub_vld_o       request to mul_ko_128b
//   sub_a_o/b_o     128-bit sub-multiplier operands
//   sub_fin_i       sub-multiplier done
//   sub_r_i         256-bit sub-multiplier product (valid with sub_fin_i)
//   dbg_state_o     current FSM state, for observation only
// ---------------------------------------------------------------------------
module mul_256b_seq #(
  parameter int ACC_W = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mul_vld_i,
  input  logic [255:0]       mul_a_i,
  input  logic [255:0]       mul_b_i,
  output logic               mul_fin_o,
  output logic [ACC_W-1:0]   mul_r_o,
  output logic               busy_o,
  output logic               sub_vld_o,
  output logic [127:0]       sub_a_o,
  output logic [127:0]       sub_b_o,
  input  logic               sub_fin_i,
  input  logic [255:0]       sub_r_i,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [255:0]       a_q;
  logic [255:0]       b_q;
  logic [ACC_W-1:0]   acc;
  logic [1:0]         idx;
  logic [1:0]         idx_nxt;
  logic               last_pass;
  logic               sqr;
  logic [8:0]         shamt;
  logic [ACC_W-1:0]   term;

`ifdef MUL_SQR_EN
  logic sqr_q;
  assign sqr = sqr_q;
`else
  assign sqr = 1'b0;
`endif

  // The final pass is always a_hi*b_hi. Squaring only skips pass 2.
  assign last_pass   = (idx == 2'd3);
  assign idx_nxt     = (sqr && (idx == 2'd1)) ? 2'd3 : idx + 2'd1;
  assign busy_o      = (state != S_IDLE);
  assign dbg_state_o = state;

  always_comb begin
    shamt = 9'd0;
    case (idx)
      2'd0:    shamt = 9'd0;
      2'd1:    shamt = sqr ? 9'd129 : 9'd128;
      2'd2:    shamt = 9'd128;
      default: shamt = 9'd256;
    endcase
  end

  // Sub-product widened to accumulator width before shifting. The largest
  // shift (256) still fits the 256-bit value inside 512 bits.
  assign term = {{(ACC_W-256){1'b0}}, sub_r_i} << shamt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mul_vld_i) state_nxt = S_RUN;
      S_RUN:  if (sub_fin_i) state_nxt = last_pass ? S_DONE : S_GAP;
      S_GAP:  state_nxt = S_RUN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. sub_vld_o and the sub operands are registered so that they
  // rise together on the accept or GAP edge, then stay stable for the whole
  // RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      idx       <= 2'd0;
      mul_fin_o <= 1'b0;
      mul_r_o   <= '0;
      sub_vld_o <= 1'b0;
      sub_a_o   <= '0;
      sub_b_o   <= '0;
`ifdef MUL_SQR_EN
      sqr_q     <= 1'b0;
`endif
    end else begin
      mul_fin_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mul_vld_i) begin
            a_q       <= mul_a_i;
            b_q       <= mul_b_i;
            acc       <= '0;
            idx       <= 2'd0;
            sub_vld_o <= 1'b1;
            sub_a_o   <= mul_a_i[127:0];
            sub_b_o   <= mul_b_i[127:0];
`ifdef MUL_SQR_EN
            sqr_q     <= (mul_a_i == mul_b_i);
`endif
          end
        end
        S_RUN: begin
          if (sub_fin_i) begin
            acc       <= acc + term;
            sub_vld_o <= 1'b0;
            if (!last_pass) idx <= idx_nxt;
          end
        end
        S_GAP: begin
          // idx[1] selects the A half and idx[0] selects the B half.
          sub_vld_o <= 1'b1;
          sub_a_o   <= idx[1] ? a_q[255:128] : a_q[127:0];
          sub_b_o   <= idx[0] ? b_q[255:128] : b_q[127:0];
        end
        S_DONE: begin
          mul_fin_o <= 1'b1;
          mul_r_o   <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_256b_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_256b_seq
//
// Testbench for mul_256b_seq. A behavioural 128x128 sub-multiplier responds
// with a programmable delay D. Each issued operation pushes its expected
// product a*b, its expected completion cycle and its expected pass count
// into queues. A monitor pops those queues on every mul_fin_o.
// ---------------------------------------------------------------------------
module tb_mul_256b_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         mul_vld_i;
  logic [255:0] mul_a_i;
  logic [255:0] mul_b_i;
  logic         mul_fin_o;
  logic [511:0] mul_r_o;
  logic         busy_o;
  logic         sub_vld_o;
  logic [127:0] sub_a_o;
  logic [127:0] sub_b_o;
  logic         sub_fin_i;
  logic [255:0] sub_r_i;
  logic [1:0]   dbg_state;

  mul_256b_seq dut (
    .clk         (clk),
    .rst         (rst),
    .mul_vld_i   (mul_vld_i),
    .mul_a_i     (mul_a_i),
    .mul_b_i     (mul_b_i),
    .mul_fin_o   (mul_fin_o),
    .mul_r_o     (mul_r_o),
    .busy_o      (busy_o),
    .sub_vld_o   (sub_vld_o),
    .sub_a_o     (sub_a_o),
    .sub_b_o     (sub_b_o),
    .sub_fin_i   (sub_fin_i),
    .sub_r_i     (sub_r_i),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [511:0] exp_q[$];
  int           lat_q[$];
  int           rise_q[$];
  logic [127:0] log_a[$];
  logic [127:0] log_b[$];
  int cur_d = 2;
  int rise_cnt = 0;
  int low_len = 0;
  int stab_err = 0;
  int gap_err = 0;
  int fin_cnt = 0;
  logic prev_vld = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] ref_prod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] wa;
    logic [511:0] wb;
    wa = {256'd0, a};
    wb = {256'd0, b};
    return wa * wb;
  endfunction

  function automatic int ref_lat(input logic [255:0] a, input logic [255:0] b, input int d);
`ifdef MUL_SQR_EN
    if (a == b) return 3 * d + 6;
`endif
    return 4 * d + 8;
  endfunction

  function automatic int ref_passes(input logic [255:0] a, input logic [255:0] b);
`ifdef MUL_SQR_EN
    if (a == b) return 3;
`endif
    return 4;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- behavioural sub-multiplier ----------------
  // fin rises D cycles after vld rises and lasts one cycle.
  logic         sm_busy = 1'b0;
  int           sm_cnt = 0;
  logic [127:0] sm_a;
  logic [127:0] sm_b;

  always @(posedge clk) begin
    sub_fin_i <= 1'b0;
    if (rst) begin
      sm_busy <= 1'b0;
      sm_cnt  <= 0;
    end else if (!sm_busy && sub_vld_o && !sub_fin_i) begin
      if (cur_d == 1) begin
        sub_fin_i <= 1'b1;
        sub_r_i   <= {128'd0, sub_a_o} * {128'd0, sub_b_o};
      end else begin
        sm_busy <= 1'b1;
        sm_cnt  <= 2;
        sm_a    <= sub_a_o;
        sm_b    <= sub_b_o;
      end
    end else if (sm_busy) begin
      if (sm_cnt >= cur_d) begin
        sub_fin_i <= 1'b1;
        sub_r_i   <= {128'd0, sm_a} * {128'd0, sm_b};
        sm_busy   <= 1'b0;
      end else begin
        sm_cnt <= sm_cnt + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (sub_vld_o && !prev_vld) begin
        if (rise_cnt > 0 && low_len != 1) gap_err++;
        rise_cnt++;
        log_a.push_back(sub_a_o);
        log_b.push_back(sub_b_o);
        low_len = 0;
      end else if (sub_vld_o && prev_vld) begin
        if (log_a.size() > 0 && (sub_a_o !== log_a[$] || sub_b_o !== log_b[$])) stab_err++;
      end else if (!sub_vld_o) begin
        low_len++;
      end
      if (mul_fin_o) begin
        fin_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_fin actual=fin_pulse required=no_pulse cyc=%0d", cyc);
        end else begin
          check("product", mul_r_o, exp_q.pop_front());
          check("latency", cyc, lat_q.pop_front());
          check("sub_passes", rise_cnt, rise_q.pop_front());
        end
        rise_cnt = 0;
      end
    end
    prev_vld = sub_vld_o;
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [255:0] a, input logic [255:0] b, input int d);
    exp_q.push_back(ref_prod(a, b));
    lat_q.push_back(cyc + 1 + ref_lat(a, b, d));
    rise_q.push_back(ref_passes(a, b));
  endtask

  task automatic do_op(input logic [255:0] a, input logic [255:0] b, input int d);
    int t;
    t = 0;
    while (busy_o && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      total++; bad++;
      $display("FAIL idle_wait actual=busy required=idle");
    end
    cur_d     = d;
    mul_a_i   = a;
    mul_b_i   = b;
    mul_vld_i = 1'b1;
    push_exp(a, b, d);
    @(negedge clk); #1;
    mul_vld_i = 1'b0;
    mul_a_i   = rand256();
    mul_b_i   = rand256();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || busy_o) && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      total++; bad++;
      $display("FAIL done_wait actual=pending=%0d required=pending=0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] ea[4];
  logic [127:0] eb[4];
  logic [511:0] e_fix;
  logic [255:0] ra;
  logic [255:0] rb;
  int           n_ops;
  int           t4;

  initial begin
    rst = 1'b1; mul_vld_i = 1'b0; mul_a_i = '0; mul_b_i = '0;
    n_ops = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_r", mul_r_o, 512'd0);
    check("reset_ctl", {busy_o, sub_vld_o, mul_fin_o}, 3'b000);
    check("reset_sub", {sub_a_o, sub_b_o}, 256'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // 1: zero operands
    do_op('0, '0, 2); n_ops++;
    wait_idle();

    // 2: partial-product ordering
    log_a.delete(); log_b.delete();
    do_op({128'h1, 128'h2}, {128'h3, 128'h4}, 2); n_ops++;
    wait_idle();
    ea[0] = 128'd2; ea[1] = 128'd2; ea[2] = 128'd1; ea[3] = 128'd1;
    eb[0] = 128'd4; eb[1] = 128'd3; eb[2] = 128'd4; eb[3] = 128'd3;
    check("t2_npass", log_a.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < log_a.size()) check("t2_sub_ops", {log_a[i], log_b[i]}, {ea[i], eb[i]});
    e_fix = (512'd3 << 256) + (512'd10 << 128) + 512'd8;
    check("t2_result", mul_r_o, e_fix);

    // 3: all-ones square
    do_op({256{1'b1}}, {256{1'b1}}, 2); n_ops++;
    wait_idle();
    e_fix = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    check("t3_result", mul_r_o, e_fix);

    // 4: reset during the pass-idx2 RUN
    ra = rand256(); rb = rand256();
    do_op(ra, rb, 2);
    t4 = 0;
    while (rise_cnt < 3 && t4 < 200) begin
      @(negedge clk); #1;
      t4++;
    end
    if (t4 >= 200) begin
      total++; bad++;
      $display("FAIL t4_wait actual=passes=%0d required=passes=3", rise_cnt);
    end
    rst = 1'b1;
    exp_q.delete(); lat_q.delete(); rise_q.delete();
    @(negedge clk); #1;
    check("t4_busy", busy_o, 1'b0);
    check("t4_sub_vld", sub_vld_o, 1'b0);
    check("t4_r", mul_r_o, 512'd0);
    check("t4_fin", mul_fin_o, 1'b0);
    rst = 1'b0;
    rise_cnt = 0;
    repeat (30) @(negedge clk);
    #1;
    do_op(256'd5, 256'd7, 2); n_ops++;
    wait_idle();
    check("t4_result", mul_r_o, 512'd35);

    // 5: vld held high, operands changing every cycle
    cur_d = 2;
    ra = rand256(); rb = rand256();
    mul_a_i = ra; mul_b_i = rb; mul_vld_i = 1'b1;
    push_exp(ra, rb, 2); n_ops++;
    for (int j = 1; j <= 35; j++) begin
      @(negedge clk); #1;
      if (j == 35) begin
        mul_vld_i = 1'b0;
      end else begin
        ra = rand256(); rb = rand256();
        mul_a_i = ra; mul_b_i = rb;
        if (j % 17 == 0) begin
          push_exp(ra, rb, 2); n_ops++;
        end
      end
    end
    wait_idle();

    // 6: random operands and random sub-multiplier delay
    for (int k = 0; k < 1000; k++) begin
      ra = rand256();
      rb = ($urandom_range(0, 19) == 0) ? ra : rand256();
      do_op(ra, rb, $urandom_range(1, 5)); n_ops++;
    end
    wait_idle();

    check("sub_operand_stability", stab_err, 0);
    check("sub_vld_gap", gap_err, 0);
    check("fin_count", fin_cnt, n_ops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
